cp0: RTL

Coprocessor-0 exception and interrupt controller, sitting at the memory stage of the pipelined MIPS core. It is the consuming end of the pipeline's exception-detect path. It takes the exception flag and 5-bit code carried down from the stage detectors, for example fetch-address error code 4, plus six hardware interrupt lines. From these it decides whether to trap, records SR/Cause/EPC, and drives the PC-redirect request and the `eret` return address. It also services `mfc0`/`mtc0` register accesses.

---
 rtl/cp0.sv | 96 +++++++++
 1 files changed

// File: rtl/cp0.sv
// Coprocessor-0: exception/interrupt arbitration, SR/Cause/EPC/PRId storage,
// mfc0/mtc0 access and the PC-redirect request for the memory stage.
module cp0 #(
  parameter logic [31:0] HANDLER_ADDR = 32'h00004180,
  parameter logic [31:0] PRID         = 32'h20221217
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] Din,
  input  logic        WE,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic        isExcIn,
  input  logic [4:0]  excCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] Dout,
  output logic [31:0] EPCOut,
  output logic [31:0] handlerPC,
  output logic        Req
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned RW     = 5;
  localparam logic [RW-1:0] R_SR    = RW'(12);
  localparam logic [RW-1:0] R_CAUSE = RW'(13);
  localparam logic [RW-1:0] R_EPC   = RW'(14);
  localparam logic [RW-1:0] R_PRID  = RW'(15);

  logic [5:0]      im;
  logic            exl;
  logic            ie;
  logic            bd;
  logic [5:0]      ip;
  logic [4:0]      exc_code;
  logic [XLEN-1:0] epc;

  logic            int_req;
  logic            exc_req;
  logic [XLEN-1:0] sr_val;
  logic [XLEN-1:0] cause_val;

  // Request is gated by reset so a trap in flight vanishes the instant reset rises.
  assign int_req = (|(HWInt & im)) & ie & ~exl & ~reset;
  assign exc_req = isExcIn & ~exl & ~reset;
  assign Req     = int_req | exc_req;

  assign sr_val    = {16'b0, im, 8'b0, exl, ie};
  assign cause_val = {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};
  assign EPCOut    = epc;
  assign handlerPC = HANDLER_ADDR;

  // A trap overrides any concurrent mtc0 or eret; eret beats an mtc0 that sets EXL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
      epc      <= '0;
    end else begin
      ip <= HWInt;
      if (Req) begin
        exl      <= 1'b1;
        exc_code <= int_req ? 5'd0 : excCodeIn;
        bd       <= BDIn;
        epc      <= BDIn ? (VPC - XLEN'(4)) : VPC;
      end else begin
        if (WE && (A2 == R_SR)) begin
          im  <= Din[15:10];
          exl <= Din[1];
          ie  <= Din[0];
        end
        if (WE && (A2 == R_EPC)) epc <= Din;
        if (EXLClr) exl <= 1'b0;
      end
    end
  end

  // mfc0 read port: stored values only, no same-cycle write bypass.
  always_comb begin
    Dout = '0;
    case (A1)
      R_SR:    Dout = sr_val;
      R_CAUSE: Dout = cause_val;
      R_EPC:   Dout = epc;
      R_PRID:  Dout = PRID;
      default: Dout = '0;
    endcase
  end

endmodule
